i2s_receiver: RTL and testbench
===============================

# i2s_receiver

Serial-audio capture block for the audio subsystem: the receive end of the I2S link that our DAC interface transmits. It deserializes BCLK/LRCLK/SDATA (from a codec ADC, or looped back from our own transmitter for self-test) into signed left/right sample pairs. It hands the pairs to the system clock domain over a valid/ready handshake. It also reports frame lock and overrun.

## Interface
- `DATA_W`, default 16: sample width in bits, MSB-first, two's complement.
- `TIMEOUT`, default 1024: number of `clk` cycles without a BCLK rise before lock is dropped.

- `clk`  in  1  system clock; must be at least 8x the BCLK frequency.
- `reset_N`  in  1  reset, asynchronous and active-low.
- `BCLK`  in  1  serial bit clock, asynchronous to `clk`.
- `LRCLK`  in  1  word select: 0 = left, 1 = right. Asynchronous.
- `SDATA`  in  1  serial data. Asynchronous.
- `sample_left`  out  DATA_W  left sample of the last delivered pair.
- `sample_right`  out  DATA_W  right sample of the last delivered pair.
- `sample_valid`  out  1  a pair is available; held until accepted.
- `sample_ready`  in  1  consumer accepts the pair when `sample_valid && sample_ready`.
- `overrun`  out  1  sticky: a pair was overwritten before it was accepted.
- `clear_overrun`  in  1  clears `overrun`.
- `locked`  out  1  framing is established.

## Operation
- **Input synchronization**
  - BCLK, LRCLK and SDATA each pass through a 2-flop synchronizer.
  - A third BCLK flop provides edge detection. A BCLK rise ("rise") is detected when sync = 1 and the delayed copy = 0.
  - LRCLK and SDATA are taken from the same sync stage as BCLK.
- **Bit attribution (I2S one-bit delay)**
  - On every rise the block registers `lr_d` (LRCLK at this rise) and `lr_dd` (LRCLK at the previous rise).
  - The SDATA bit sampled at a rise belongs to channel `lr_dd`.
  - Bit index: 0 when `lr_dd` differs from its value at the previous rise; otherwise index+1, saturating at DATA_W.
  - Index < DATA_W: the bit is shifted into that channel's shift register, MSB first.
  - Index == DATA_W-1: the channel's word is complete.
  - Bits at index ≥ DATA_W are ignored, so slots longer than DATA_W are allowed.
  - A 16-BCLK slot is allowed: its LSB arrives on the rise where the new LRCLK value is first seen.
- **Framing error:** the channel changes (index reset) while the previous slot's word is incomplete.
- **State machine (ACQUIRE, TRAIN, LOCKED)**
  - ACQUIRE → TRAIN on the first rise whose bit starts a left slot (index 0, channel 0).
  - TRAIN → LOCKED when the right word completes and the left word of the same frame completed without a framing error.
  - Any state → ACQUIRE on a framing error.
  - Any state → ACQUIRE on TIMEOUT consecutive `clk` cycles with no rise. The timeout counter resets on every rise.
  - `locked` = (state == LOCKED). It is registered, so it rises in the same cycle as the pair that achieves lock.
- **Pair delivery**
  - A pair is delivered on right-word completion in TRAIN→LOCKED or in LOCKED.
  - Delivery loads `sample_left`/`sample_right` and sets `sample_valid`.
  - Pairs are never delivered in ACQUIRE. In TRAIN, delivery happens only on the transition to LOCKED.
- **Handshake**
  - `sample_valid && sample_ready` with no new pair: valid clears next cycle.
  - New pair while valid=1 and ready=0: the output registers are overwritten (newest wins), valid stays 1, and `overrun` sets.
  - New pair in the same cycle as an accept: load the new pair, valid stays 1, no overrun.
  - Entering ACQUIRE does not disturb a pending valid pair or the output registers.
- **Overrun flag**
  - `clear_overrun` clears `overrun`.
  - If `clear_overrun` and a new overrun occur in the same cycle, the set wins.

## Timing
- Reset (asynchronous, immediate) values:
  - `sample_left`, `sample_right` = 0.
  - `sample_valid`, `overrun`, `locked` = 0.
  - State = ACQUIRE; shift registers, indices and timeout counter = 0.
- Latency: `sample_valid` goes high at the 4th `clk` rising edge after the `clk` edge that first samples the right-LSB BCLK rise high on the pin (2 sync + 1 edge + 1 output register).
- `sample_valid` stays high for 1 cycle when `sample_ready` is held at 1.
- Only the BCLK rising edge is used; BCLK falling edges are ignored.
- Minimum BCLK high and low time: 3 `clk` cycles each.

## Test plan
- 64 BCLK/frame, left=16'h1234, right=16'hABCD, ready=1:
  - First full frame → `locked`=1 and one pair 1234/ABCD.
  - Then exactly one 1-cycle valid per frame thereafter.
- 32 BCLK/frame (16-BCLK slots), left=16'h8001, right=16'h7FFE: captured exactly, including LSBs that land on the LRCLK-change rise.
- ready=0 for two frames (L=0x0001/R=0x0002, then L=0x0003/R=0x0004):
  - `overrun`=1, outputs 0003/0004, valid held.
  - Assert ready → valid clears.
  - Pulse `clear_overrun` → `overrun`=0.
- One 10-BCLK left slot inside a locked stream → `locked`=0 within 4 cycles and no pair for that frame. Next clean frame → relock and pair delivered.
- BCLK stopped for TIMEOUT+10 clk with a pair pending → `locked`=0, pending pair and valid retained. Restart BCLK → relock after one frame.
- `reset_N` low mid-frame with valid=1 → all outputs 0 immediately. After release, no pair is delivered before a left-slot start and a full good frame.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S receiver: syncs BCLK/LRCLK/SDATA into clk, deserializes signed L/R
// samples, tracks frame lock and hands pairs out over valid/ready.
// Ports: clk, reset_N (async low); BCLK, LRCLK, SDATA serial inputs;
// sample_left/right, sample_valid, sample_ready; overrun, clear_overrun;
// locked.
module i2s_receiver #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              BCLK,
  input  logic              LRCLK,
  input  logic              SDATA,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              clear_overrun,
  output logic              locked
);

  localparam int IW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDX_SAT  = IW'(DATA_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRAIN   = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Synchronizers; bit 1 is the synced value, bclk bit 2 the edge delay.
  logic [2:0] bclk_q;
  logic [1:0] lr_s_q;
  logic [1:0] sd_s_q;

  // Edge stage
  logic rise_q;
  logic lr_e_q;
  logic sd_e_q;

  // Bit stage
  logic              lr_d_q;
  logic              lr_dd_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     idx_d;
  logic              done_q;
  logic [DATA_W-1:0] sh_l_q;
  logic [DATA_W-1:0] sh_r_q;
  logic [DATA_W-1:0] left_word_q;
  logic [DATA_W-1:0] right_word_q;
  logic [DATA_W-1:0] word_nxt;
  logic              ch;
  logic              chg;
  logic              in_word;
  logic              cmp;

  // Per-rise events feeding the control stage
  logic ev_rise_q;
  logic ev_lstart_q;
  logic ev_ferr_q;
  logic ev_lcmp_q;
  logic ev_rcmp_q;

  // Control / output stage
  state_e            state_q;
  logic              locked_q;
  logic [TW-1:0]     tmo_q;
  logic              tmo_hit;
  logic              abort;
  logic              left_ok_q;
  logic              deliver;
  logic              accept;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] right_q;
  logic              valid_q;
  logic              ovr_q;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      bclk_q <= '0;
      lr_s_q <= '0;
      sd_s_q <= '0;
      rise_q <= 1'b0;
      lr_e_q <= 1'b0;
      sd_e_q <= 1'b0;
    end else begin
      bclk_q <= {bclk_q[1:0], BCLK};
      lr_s_q <= {lr_s_q[0], LRCLK};
      sd_s_q <= {sd_s_q[0], SDATA};
      rise_q <= bclk_q[1] & ~bclk_q[2];
      lr_e_q <= lr_s_q[1];
      sd_e_q <= sd_s_q[1];
    end
  end

  // I2S one-bit delay: the bit at this rise belongs to the LRCLK value
  // seen at the previous rise.
  assign ch  = lr_d_q;
  assign chg = lr_d_q ^ lr_dd_q;

  always_comb begin
    idx_d = idx_q;
    if (chg) begin
      idx_d = '0;
    end else if (idx_q != IDX_SAT) begin
      idx_d = idx_q + IW'(1);
    end
  end

  assign in_word  = idx_d < IDX_SAT;
  assign cmp      = rise_q && (idx_d == IDX_LAST);
  assign word_nxt = ch ? {sh_r_q[DATA_W-2:0], sd_e_q}
                       : {sh_l_q[DATA_W-2:0], sd_e_q};

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      lr_d_q       <= 1'b0;
      lr_dd_q      <= 1'b0;
      idx_q        <= '0;
      done_q       <= 1'b0;
      sh_l_q       <= '0;
      sh_r_q       <= '0;
      left_word_q  <= '0;
      right_word_q <= '0;
      ev_rise_q    <= 1'b0;
      ev_lstart_q  <= 1'b0;
      ev_ferr_q    <= 1'b0;
      ev_lcmp_q    <= 1'b0;
      ev_rcmp_q    <= 1'b0;
    end else begin
      ev_rise_q   <= rise_q;
      ev_lstart_q <= rise_q & chg & ~ch;
      ev_ferr_q   <= rise_q & chg & ~done_q;
      ev_lcmp_q   <= cmp & ~ch;
      ev_rcmp_q   <= cmp & ch;
      if (rise_q) begin
        lr_d_q  <= lr_e_q;
        lr_dd_q <= lr_d_q;
        idx_q   <= idx_d;
        if (in_word) begin
          if (ch) sh_r_q <= word_nxt;
          else    sh_l_q <= word_nxt;
        end
        if (cmp && !ch) left_word_q  <= word_nxt;
        if (cmp && ch)  right_word_q <= word_nxt;
        if (chg)        done_q <= 1'b0;
        else if (cmp)   done_q <= 1'b1;
      end
    end
  end

  assign tmo_hit = !ev_rise_q && (tmo_q == TMO_LAST);
  assign abort   = ev_ferr_q || tmo_hit;
  assign deliver = ev_rcmp_q &&
                   ((state_q == LOCKED) ||
                    ((state_q == TRAIN) && left_ok_q));
  assign accept  = valid_q && sample_ready;

  // In ACQUIRE a left-slot start begins training even if the slot it
  // interrupts was partial: that is the normal way to join a stream.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q  <= ACQUIRE;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        ACQUIRE: begin
          if (ev_lstart_q) state_q <= TRAIN;
        end
        TRAIN: begin
          if (abort) begin
            state_q <= ACQUIRE;
          end else if (ev_rcmp_q && left_ok_q) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (abort) begin
            state_q  <= ACQUIRE;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ACQUIRE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      tmo_q     <= '0;
      left_ok_q <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (ev_rise_q)     tmo_q <= '0;
      else if (!tmo_hit) tmo_q <= tmo_q + TW'(1);
      if (ev_lstart_q)    left_ok_q <= 1'b0;
      else if (ev_lcmp_q) left_ok_q <= 1'b1;
      if (deliver) begin
        left_q  <= left_word_q;
        right_q <= right_word_q;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      // A fresh overrun beats a simultaneous clear.
      if (deliver && valid_q && !sample_ready) ovr_q <= 1'b1;
      else if (clear_overrun)                  ovr_q <= 1'b0;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: frame table plus hand sequences for overrun,
// timeout and reset; delivered pairs are checked against a queue.
module tb_i2s_receiver;

  localparam int TO = 128;

  logic        clk;
  logic        reset_N;
  logic        BCLK;
  logic        LRCLK;
  logic        SDATA;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        clear_overrun;
  logic        locked;

  i2s_receiver #(.DATA_W(16), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset_N      (reset_N),
    .BCLK         (BCLK),
    .LRCLK        (LRCLK),
    .SDATA        (SDATA),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clear_overrun(clear_overrun),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          s;
    int          len_l;
    logic [15:0] l;
    logic [15:0] r;
    bit          pair;
    bit          lock;
    bit          lat;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        carry   = 1'b0;
  bit          lat_arm = 1'b0;
  time         t_lsb   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sample_valid && sample_ready) begin
      if (lat_arm) begin
        chk("latency_ns", 32'($time - t_lsb), 32'd50);
        lat_arm = 1'b0;
      end
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pair: got %h%h expected none",
                 sample_left, sample_right);
      end else begin
        chk("pair", {sample_left, sample_right}, exp_q.pop_front());
      end
    end
  end

  task automatic bit_rise(input logic lr, input logic b);
    BCLK  = 1'b0;
    LRCLK = lr;
    SDATA = b;
    #40;
    BCLK  = 1'b1;
    #40;
  endtask

  task automatic slot(input logic lr, input int len,
                      input logic [15:0] w, input bit lat);
    logic b;
    for (int j = 0; j < len; j++) begin
      if (j == 0)       b = carry;
      else if (j <= 16) b = w[16-j];
      else              b = 1'b0;
      if (lat && j == 16) begin
        t_lsb   = $time + 40;
        lat_arm = 1'b1;
      end
      bit_rise(lr, b);
    end
    carry = (len == 16) ? w[0] : 1'b0;
  endtask

  task automatic frame(input int s, input int len_l,
                       input logic [15:0] l, input logic [15:0] r,
                       input bit pair, input bit lat);
    if (pair) exp_q.push_back({l, r});
    slot(1'b0, len_l, l, 1'b0);
    slot(1'b1, s, r, lat);
  endtask

  task automatic set_ready(input logic v);
    @(negedge clk);
    #6 sample_ready = v;
    #4;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{32, 32, 16'h1234, 16'hABCD, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{32, 32, 16'h1234, 16'hABCD, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{32, 32, 16'h1234, 16'hABCD, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16, 16, 16'h8001, 16'h7FFE, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{16, 16, 16'h8001, 16'h7FFE, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16, 16, 16'h8001, 16'h7FFE, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{32, 10, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32, 32, 16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 1'b0};

    reset_N       = 1'b0;
    BCLK          = 1'b0;
    LRCLK         = 1'b0;
    SDATA         = 1'b0;
    sample_ready  = 1'b1;
    clear_overrun = 1'b0;
    #2;
    chk("rst_left",   32'(sample_left),  32'h0);
    chk("rst_right",  32'(sample_right), 32'h0);
    chk("rst_valid",  32'(sample_valid), 32'h0);
    chk("rst_ovr",    32'(overrun),      32'h0);
    chk("rst_locked", 32'(locked),       32'h0);
    #21 reset_N = 1'b1;
    #7;

    // Tail of a right slot so the first left start is visible.
    slot(1'b1, 4, 16'h0000, 1'b0);

    for (int i = 0; i < 8; i++) begin
      frame(tbl[i].s, tbl[i].len_l, tbl[i].l, tbl[i].r,
            tbl[i].pair, tbl[i].lat);
      chk($sformatf("row%0d_locked", i), 32'(locked), 32'(tbl[i].lock));
    end

    // Overrun: two frames without ready, newest pair wins.
    set_ready(1'b0);
    frame(32, 32, 16'h0001, 16'h0002, 1'b0, 1'b0);
    frame(32, 32, 16'h0003, 16'h0004, 1'b1, 1'b0);
    chk("ovr_flag",  32'(overrun),      32'h1);
    chk("ovr_left",  32'(sample_left),  32'h0003);
    chk("ovr_right", 32'(sample_right), 32'h0004);
    chk("ovr_valid", 32'(sample_valid), 32'h1);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    chk("ovr_valid_clr", 32'(sample_valid), 32'h0);
    chk("ovr_sticky",    32'(overrun),      32'h1);
    @(negedge clk);
    #6 clear_overrun = 1'b1;
    @(negedge clk);
    #6 clear_overrun = 1'b0;
    repeat (2) @(negedge clk);
    chk("ovr_cleared", 32'(overrun), 32'h0);

    // Timeout with a pending pair.
    set_ready(1'b0);
    frame(32, 32, 16'h1111, 16'h2222, 1'b1, 1'b0);
    repeat (TO + 10) @(negedge clk);
    chk("tmo_locked", 32'(locked),       32'h0);
    chk("tmo_valid",  32'(sample_valid), 32'h1);
    chk("tmo_left",   32'(sample_left),  32'h1111);
    chk("tmo_right",  32'(sample_right), 32'h2222);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    frame(32, 32, 16'h4242, 16'h2424, 1'b1, 1'b0);
    chk("tmo_relock", 32'(locked), 32'h1);

    // Reset mid-frame with a valid pair.
    set_ready(1'b0);
    frame(32, 32, 16'h7777, 16'h8888, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(sample_valid), 32'h1);
    slot(1'b0, 10, 16'h9999, 1'b0);
    #3 reset_N = 1'b0;
    #1;
    chk("mid_rst_left",   32'(sample_left),  32'h0);
    chk("mid_rst_right",  32'(sample_right), 32'h0);
    chk("mid_rst_valid",  32'(sample_valid), 32'h0);
    chk("mid_rst_locked", 32'(locked),       32'h0);
    #19 reset_N = 1'b1;
    #7;
    set_ready(1'b1);
    slot(1'b0, 6, 16'h0000, 1'b0);
    slot(1'b1, 32, 16'hBEEF, 1'b0);
    chk("post_rst_unlocked", 32'(locked), 32'h0);
    frame(32, 32, 16'h1357, 16'h2468, 1'b1, 1'b0);
    chk("post_rst_locked", 32'(locked), 32'h1);

    repeat (20) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
